branch_rs: RTL and testbench

BRANCH_RS -- requirements
Module: branch_rs

---
 rtl/branch_rs_if.sv | 46 ++++
 rtl/branch_rs.sv | 129 ++++++++++++
 tb/tb_branch_rs.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_rs_if.sv
// Bundle of dispatch, wakeup-broadcast, flush and issue signals for the branch reservation station.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 5
`endif

interface branch_rs_if;
  logic                              flush_i;
  logic                              enq_valid_i;
  logic                              enq_ready_o;
  logic [63:0]                       enq_pc_i;
  logic [31:0]                       enq_inst_i;
  logic [3:0]                        enq_func_code_i;
  logic [`SCOREBOARD_SIZE_WIDTH-1:0] enq_sid_i;
  logic                              enq_rs1_rdy_i;
  logic                              enq_rs2_rdy_i;
  logic [`SCOREBOARD_SIZE_WIDTH-1:0] enq_rs1_tag_i;
  logic [`SCOREBOARD_SIZE_WIDTH-1:0] enq_rs2_tag_i;
  logic [63:0]                       enq_rs1_value_i;
  logic [63:0]                       enq_rs2_value_i;
  logic                              wb_valid_i;
  logic [`SCOREBOARD_SIZE_WIDTH-1:0] wb_sid_i;
  logic [63:0]                       wb_value_i;
  logic                              branch_valid_o;
  logic [63:0]                       branch_pc_o;
  logic [31:0]                       branch_inst_o;
  logic [`SCOREBOARD_SIZE_WIDTH-1:0] branch_sid_o;
  logic [63:0]                       rs1_value_o;
  logic [63:0]                       rs2_value_o;
  logic [3:0]                        func_code_o;

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_inst_i, enq_func_code_i, enq_sid_i,
           enq_rs1_rdy_i, enq_rs2_rdy_i, enq_rs1_tag_i, enq_rs2_tag_i,
           enq_rs1_value_i, enq_rs2_value_i, wb_valid_i, wb_sid_i, wb_value_i,
    output enq_ready_o, branch_valid_o, branch_pc_o, branch_inst_o, branch_sid_o,
           rs1_value_o, rs2_value_o, func_code_o
  );

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_inst_i, enq_func_code_i, enq_sid_i,
           enq_rs1_rdy_i, enq_rs2_rdy_i, enq_rs1_tag_i, enq_rs2_tag_i,
           enq_rs1_value_i, enq_rs2_value_i, wb_valid_i, wb_sid_i, wb_value_i,
    input  enq_ready_o, branch_valid_o, branch_pc_o, branch_inst_o, branch_sid_o,
           rs1_value_o, rs2_value_o, func_code_o
  );
endinterface

// File: rtl/branch_rs.sv
// In-order branch reservation station: circular queue with operand wakeup, issuing from head only.
// Optional macro BRANCH_RS_WAKEUP_BYPASS_EN lets a same-cycle broadcast complete the head's operands.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 5
`endif

module branch_rs #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_rs_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = `SCOREBOARD_SIZE_WIDTH;

  logic [DEPTH-1:0] valid_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic [63:0]      pc_r      [DEPTH];
  logic [31:0]      inst_r    [DEPTH];
  logic [3:0]       func_r    [DEPTH];
  logic [SW-1:0]    sid_r     [DEPTH];
  logic [SW-1:0]    rs1_tag_r [DEPTH];
  logic [SW-1:0]    rs2_tag_r [DEPTH];
  logic [63:0]      rs1_val_r [DEPTH];
  logic [63:0]      rs2_val_r [DEPTH];
  logic [DEPTH-1:0] rs1_rdy_r;
  logic [DEPTH-1:0] rs2_rdy_r;

  logic        enq_ready_s;
  logic        enq_fire_s;
  logic        issue_s;
  logic        rs1_hit_s;
  logic        rs2_hit_s;
  logic        head_rs1_ok_s;
  logic        head_rs2_ok_s;
  logic [63:0] head_rs1_val_s;
  logic [63:0] head_rs2_val_s;
  logic        enq_rs1_rdy_s;
  logic        enq_rs2_rdy_s;
  logic [63:0] enq_rs1_val_s;
  logic [63:0] enq_rs2_val_s;

  // Handshake, issue qualification and operand capture for the incoming entry.
  always_comb begin
    enq_ready_s = rst_n & ~bus.flush_i & (count_r < CNT_W'(DEPTH));
    enq_fire_s  = bus.enq_valid_i & enq_ready_s;
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
    rs1_hit_s = ~rs1_rdy_r[head_r] & bus.wb_valid_i & (bus.wb_sid_i == rs1_tag_r[head_r]);
    rs2_hit_s = ~rs2_rdy_r[head_r] & bus.wb_valid_i & (bus.wb_sid_i == rs2_tag_r[head_r]);
`else
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
`endif
    head_rs1_ok_s  = rs1_rdy_r[head_r] | rs1_hit_s;
    head_rs2_ok_s  = rs2_rdy_r[head_r] | rs2_hit_s;
    head_rs1_val_s = rs1_hit_s ? bus.wb_value_i : rs1_val_r[head_r];
    head_rs2_val_s = rs2_hit_s ? bus.wb_value_i : rs2_val_r[head_r];
    issue_s = rst_n & ~bus.flush_i & valid_r[head_r] & head_rs1_ok_s & head_rs2_ok_s;

    // A broadcast landing in the dispatch cycle must not be lost for the new entry.
    enq_rs1_rdy_s = bus.enq_rs1_rdy_i |
                    (bus.wb_valid_i & (bus.wb_sid_i == bus.enq_rs1_tag_i));
    enq_rs2_rdy_s = bus.enq_rs2_rdy_i |
                    (bus.wb_valid_i & (bus.wb_sid_i == bus.enq_rs2_tag_i));
    enq_rs1_val_s = bus.enq_rs1_rdy_i ? bus.enq_rs1_value_i : bus.wb_value_i;
    enq_rs2_val_s = bus.enq_rs2_rdy_i ? bus.enq_rs2_value_i : bus.wb_value_i;
  end

  assign bus.enq_ready_o    = enq_ready_s;
  assign bus.branch_valid_o = issue_s;
  assign bus.branch_pc_o    = pc_r[head_r];
  assign bus.branch_inst_o  = inst_r[head_r];
  assign bus.branch_sid_o   = sid_r[head_r];
  assign bus.func_code_o    = func_r[head_r];
  assign bus.rs1_value_o    = head_rs1_val_s;
  assign bus.rs2_value_o    = head_rs2_val_s;

  // Queue control: valid bits, wrapping pointers and occupancy; reset and flush both empty it.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_i) begin
      valid_r <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (issue_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
      end
      if (enq_fire_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(enq_fire_s) - CNT_W'(issue_s);
    end
  end

  // Entry payload: written on enqueue, operands woken by the result broadcast; never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire_s && (tail_r == PTR_W'(i))) begin
        pc_r[i]      <= bus.enq_pc_i;
        inst_r[i]    <= bus.enq_inst_i;
        func_r[i]    <= bus.enq_func_code_i;
        sid_r[i]     <= bus.enq_sid_i;
        rs1_tag_r[i] <= bus.enq_rs1_tag_i;
        rs2_tag_r[i] <= bus.enq_rs2_tag_i;
        rs1_rdy_r[i] <= enq_rs1_rdy_s;
        rs2_rdy_r[i] <= enq_rs2_rdy_s;
        rs1_val_r[i] <= enq_rs1_val_s;
        rs2_val_r[i] <= enq_rs2_val_s;
      end else begin
        if (valid_r[i] && !rs1_rdy_r[i] && bus.wb_valid_i && (bus.wb_sid_i == rs1_tag_r[i])) begin
          rs1_rdy_r[i] <= 1'b1;
          rs1_val_r[i] <= bus.wb_value_i;
        end
        if (valid_r[i] && !rs2_rdy_r[i] && bus.wb_valid_i && (bus.wb_sid_i == rs2_tag_r[i])) begin
          rs2_rdy_r[i] <= 1'b1;
          rs2_val_r[i] <= bus.wb_value_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_rs.sv
// Randomized and directed bench for branch_rs against a queue-based reference model.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 5
`endif

module tb_branch_rs;
  localparam int DEPTH = 4;
  localparam int SW    = `SCOREBOARD_SIZE_WIDTH;
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [63:0]   pc;
    logic [31:0]   inst;
    logic [3:0]    fc;
    logic [SW-1:0] sid;
    bit            r1;
    bit            r2;
    logic [SW-1:0] t1;
    logic [SW-1:0] t2;
    logic [63:0]   v1;
    logic [63:0]   v2;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];

  branch_rs_if bus ();

  branch_rs #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.flush_i         = 1'b0;
    bus.enq_valid_i     = 1'b0;
    bus.enq_pc_i        = 64'd0;
    bus.enq_inst_i      = 32'd0;
    bus.enq_func_code_i = 4'd0;
    bus.enq_sid_i       = '0;
    bus.enq_rs1_rdy_i   = 1'b0;
    bus.enq_rs2_rdy_i   = 1'b0;
    bus.enq_rs1_tag_i   = '0;
    bus.enq_rs2_tag_i   = '0;
    bus.enq_rs1_value_i = 64'd0;
    bus.enq_rs2_value_i = 64'd0;
    bus.wb_valid_i      = 1'b0;
    bus.wb_sid_i        = '0;
    bus.wb_value_i      = 64'd0;
  endtask

  task automatic drive_enq(input logic [63:0] pc, input logic [3:0] fc, input logic [SW-1:0] sid,
                           input bit r1, input logic [SW-1:0] t1, input logic [63:0] v1,
                           input bit r2, input logic [SW-1:0] t2, input logic [63:0] v2);
    bus.enq_valid_i     = 1'b1;
    bus.enq_pc_i        = pc;
    bus.enq_inst_i      = $urandom;
    bus.enq_func_code_i = fc;
    bus.enq_sid_i       = sid;
    bus.enq_rs1_rdy_i   = r1;
    bus.enq_rs1_tag_i   = t1;
    bus.enq_rs1_value_i = v1;
    bus.enq_rs2_rdy_i   = r2;
    bus.enq_rs2_tag_i   = t2;
    bus.enq_rs2_value_i = v2;
  endtask

  task automatic drive_wb(input bit v, input logic [SW-1:0] sid, input logic [63:0] val);
    bus.wb_valid_i = v;
    bus.wb_sid_i   = sid;
    bus.wb_value_i = val;
  endtask

  // One clock: compare outputs with the model, then advance the model across the edge.
  task automatic cycle();
    ent_t        e;
    bit          rdy_e, bv_e, r1_e, r2_e;
    logic [63:0] v1_e, v2_e;
    #1;
    rdy_e = rst_n && !bus.flush_i && (q.size() < DEPTH);
    bv_e  = 1'b0;
    v1_e  = 64'd0;
    v2_e  = 64'd0;
    if (q.size() > 0) begin
      r1_e = q[0].r1 || (BYP && bus.wb_valid_i && (bus.wb_sid_i == q[0].t1));
      r2_e = q[0].r2 || (BYP && bus.wb_valid_i && (bus.wb_sid_i == q[0].t2));
      v1_e = q[0].r1 ? q[0].v1 : bus.wb_value_i;
      v2_e = q[0].r2 ? q[0].v2 : bus.wb_value_i;
      bv_e = rst_n && !bus.flush_i && r1_e && r2_e;
    end
    check_val("enq_ready", bus.enq_ready_o, rdy_e);
    check_val("issue_valid", bus.branch_valid_o, bv_e);
    if (bv_e) begin
      check_val("issue_pc", bus.branch_pc_o, q[0].pc);
      check_val("issue_inst", bus.branch_inst_o, q[0].inst);
      check_val("issue_sid", bus.branch_sid_o, q[0].sid);
      check_val("issue_func", bus.func_code_o, q[0].fc);
      check_val("issue_rs1", bus.rs1_value_o, v1_e);
      check_val("issue_rs2", bus.rs2_value_o, v2_e);
    end
    @(posedge clk);
    if (!rst_n || bus.flush_i) begin
      q.delete();
    end else begin
      if (bv_e) void'(q.pop_front());
      foreach (q[i]) begin
        if (!q[i].r1 && bus.wb_valid_i && (bus.wb_sid_i == q[i].t1)) begin
          q[i].r1 = 1'b1;
          q[i].v1 = bus.wb_value_i;
        end
        if (!q[i].r2 && bus.wb_valid_i && (bus.wb_sid_i == q[i].t2)) begin
          q[i].r2 = 1'b1;
          q[i].v2 = bus.wb_value_i;
        end
      end
      if (bus.enq_valid_i && rdy_e) begin
        e.pc   = bus.enq_pc_i;
        e.inst = bus.enq_inst_i;
        e.fc   = bus.enq_func_code_i;
        e.sid  = bus.enq_sid_i;
        e.t1   = bus.enq_rs1_tag_i;
        e.t2   = bus.enq_rs2_tag_i;
        e.r1   = bus.enq_rs1_rdy_i || (bus.wb_valid_i && (bus.wb_sid_i == bus.enq_rs1_tag_i));
        e.r2   = bus.enq_rs2_rdy_i || (bus.wb_valid_i && (bus.wb_sid_i == bus.enq_rs2_tag_i));
        e.v1   = bus.enq_rs1_rdy_i ? bus.enq_rs1_value_i : bus.wb_value_i;
        e.v2   = bus.enq_rs2_rdy_i ? bus.enq_rs2_value_i : bus.wb_value_i;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // jal, both operands ready: issues the next cycle
    drive_enq(64'h1000, 4'b0111, 5'd1, 1'b1, 5'd0, 64'h11, 1'b1, 5'd0, 64'h22);
    cycle();
    drive_idle();
    #1;
    check_val("jal_valid", bus.branch_valid_o, 64'd1);
    check_val("jal_pc", bus.branch_pc_o, 64'h1000);
    check_val("jal_func", bus.func_code_o, 64'h7);
    cycle();
    cycle();

    // beq waiting on tag 5, woken two cycles later
    drive_enq(64'h1100, 4'b0100, 5'd2, 1'b0, 5'd5, 64'd0, 1'b1, 5'd0, 64'h33);
    cycle();
    drive_idle();
    cycle();
    drive_wb(1'b1, 5'd5, 64'h2A);
    #1;
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
    check_val("beq_bypass_valid", bus.branch_valid_o, 64'd1);
    check_val("beq_bypass_rs1", bus.rs1_value_o, 64'h2A);
`else
    check_val("beq_wait_valid", bus.branch_valid_o, 64'd0);
`endif
    cycle();
    drive_idle();
`ifndef BRANCH_RS_WAKEUP_BYPASS_EN
    #1;
    check_val("beq_valid", bus.branch_valid_o, 64'd1);
    check_val("beq_rs1", bus.rs1_value_o, 64'h2A);
`endif
    cycle();
    cycle();

    // fill with the head blocked on tag 3; younger ready entries must wait
    drive_enq(64'h1200, 4'b0100, 5'd10, 1'b0, 5'd3, 64'd0, 1'b1, 5'd0, 64'h1);
    cycle();
    for (int i = 1; i < DEPTH; i++) begin
      drive_enq(64'h1200 + 64'(i), 4'b0101, 5'(10 + i), 1'b1, 5'd0, 64'(i), 1'b1, 5'd0, 64'(i + 8));
      cycle();
    end
    drive_idle();
    #1;
    check_val("full_ready", bus.enq_ready_o, 64'd0);
    check_val("full_blocked", bus.branch_valid_o, 64'd0);
    cycle();
    cycle();
    drive_wb(1'b1, 5'd3, 64'h3333);
    cycle();
    drive_idle();
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    // rs2 captured from a broadcast in the dispatch cycle
    drive_enq(64'h1300, 4'b0100, 5'd4, 1'b1, 5'd0, 64'h44, 1'b0, 5'd7, 64'd0);
    drive_wb(1'b1, 5'd7, 64'h7777);
    cycle();
    drive_idle();
    #1;
    check_val("cap_valid", bus.branch_valid_o, 64'd1);
    check_val("cap_rs2", bus.rs2_value_o, 64'h7777);
    cycle();

    // flush with three held entries and a concurrent enqueue
    for (int i = 0; i < 3; i++) begin
      drive_enq(64'h1400 + 64'(i), 4'b0100, 5'(20 + i), 1'b0, 5'd9, 64'd0, 1'b1, 5'd0, 64'd0);
      cycle();
    end
    drive_enq(64'h1500, 4'b0111, 5'd30, 1'b1, 5'd0, 64'd0, 1'b1, 5'd0, 64'd0);
    bus.flush_i = 1'b1;
    #1;
    check_val("flush_no_issue", bus.branch_valid_o, 64'd0);
    check_val("flush_no_enq", bus.enq_ready_o, 64'd0);
    cycle();
    drive_idle();
    #1;
    check_val("post_flush_ready", bus.enq_ready_o, 64'd1);
    check_val("post_flush_empty", bus.branch_valid_o, 64'd0);
    cycle();

    // back-to-back enqueue/issue pairs wrap the pointers
    drive_enq(64'h2000, 4'b0111, 5'd0, 1'b1, 5'd0, 64'd0, 1'b1, 5'd0, 64'd0);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      drive_enq(64'h2000 + 64'(i), 4'b0111, 5'(i), 1'b1, 5'd0, 64'(i), 1'b1, 5'd0, 64'(i));
      #1;
      check_val("wrap_valid", bus.branch_valid_o, 64'd1);
      check_val("wrap_pc", bus.branch_pc_o, 64'h2000 + 64'(i - 1));
      cycle();
    end
    drive_idle();
    cycle();

    // random traffic including mid-run flushes and resets
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive_idle();
      bus.flush_i = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_enq({$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? 4'b0111 : (($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b0100),
                  SW'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      if ($urandom_range(0, 2) == 0) drive_wb(1'b1, SW'($urandom_range(0, 7)), {$urandom, $urandom});
      cycle();
    end
    rst_n = 1'b1;
    drive_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
